// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a state register plus a combinational decode
// of that state into PC, IR, memory, register-file and ALU-source strobes.
// Strobes that depend on the memory handshake or the ALU zero flag are gated
// live, so a stall never advances the PC and a not-taken beq never branches.
module mips_multicycle_control (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       branch,
   output logic       jump,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [3:0] state,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t state_reg;
   state_t state_next;

   assign state = state_reg;

   // State register; reset aborts whatever instruction is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_reg <= S_FETCH;
      else
         state_reg <= state_next;
   end

   // Next-state selection; memory states hold until the handshake completes.
   always_comb begin
      state_next = S_FETCH;
      case (state_reg)
         S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXEC;
               OP_BEQ:       state_next = S_BRANCH;
               OP_J:         state_next = S_JUMP;
               OP_ADDI:      state_next = S_ADDIEX;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)
               state_next = S_MEMRD;
            else if (opcode == OP_SW)
               state_next = S_MEMWR;
            else
               state_next = S_FETCH;
         end
         S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_next = S_FETCH;
         S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_next = S_ALUWB;
         S_ALUWB:  state_next = S_FETCH;
         S_ADDIEX: state_next = S_ADDIWB;
         S_ADDIWB: state_next = S_FETCH;
         S_BRANCH: state_next = S_FETCH;
         S_JUMP:   state_next = S_FETCH;
         default:  state_next = S_FETCH;
      endcase
   end

   // Output decode; everything is held at zero while reset is asserted so no
   // partial strobe survives the falling edge of reset_n.
   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      illegal_op = 1'b0;
      if (reset_n) begin
         case (state_reg)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               case (opcode)
                  OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                  default:                                   illegal_op = 1'b1;
               endcase
            end
            S_MEMADR, S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b01;
               branch    = zero;
            end
            S_JUMP:   jump = 1'b1;
            default: begin
               pc_write = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: each instruction is expanded into its
// expected per-cycle control vector from the instruction-level rules, then
// the DUT is stepped and compared cycle by cycle.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, branch, jump, ir_write, mem_read, mem_write, i_or_d;
   logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;

   mips_multicycle_control dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .branch(branch),
      .jump(jump), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // Observed vector layout (bit positions)
   localparam int PCW = 19, BR = 18, JMP = 17, IRW = 16, MR = 15, MW = 14;
   localparam int IOD = 13, RW = 12, RD = 11, M2R = 10, SA = 9, ILL = 4;

   logic [19:0] obs;
   assign obs = {pc_write, branch, jump, ir_write, mem_read, mem_write, i_or_d,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                 illegal_op, state};

   typedef struct {
      logic [19:0] e;
      logic [5:0]  op;
      logic        mr;
      logic        z;
   } step_t;

   step_t q[$];

   function automatic logic [19:0] ctl(input int st, input int sb, input int aop);
      logic [19:0] e;
      e = '0;
      e[3:0] = 4'(st);
      e[8:7] = 2'(sb);
      e[6:5] = 2'(aop);
      return e;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [19:0] e, input logic [5:0] op, input logic mr, input logic z);
      step_t s;
      s.e = e; s.op = op; s.mr = mr; s.z = z;
      q.push_back(s);
   endtask

   // Expected cycles of one instruction. trunc drops the completing memory
   // cycle and everything after it (used for the mid-access reset).
   task automatic gen(input logic [5:0] op, input logic z, input int nf, input int nm, input bit trunc);
      logic [19:0] e;
      bit legal;
      for (int i = 0; i <= nf; i++) begin
         e = ctl(0, 1, 0);
         e[MR] = 1'b1;
         if (i == nf) begin e[PCW] = 1'b1; e[IRW] = 1'b1; end
         push(e, op, (i == nf), rnd());
      end
      legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
              (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
      e = ctl(1, 3, 0);
      e[ILL] = !legal;
      push(e, op, rnd(), rnd());
      if (op == 6'b100011 || op == 6'b101011) begin
         e = ctl(2, 2, 0); e[SA] = 1'b1;
         push(e, op, rnd(), rnd());
         for (int i = 0; i <= nm; i++) begin
            if (trunc && i == nm) return;
            e = ctl((op == 6'b100011) ? 3 : 5, 0, 0);
            e[IOD] = 1'b1;
            if (op == 6'b100011) e[MR] = 1'b1; else e[MW] = 1'b1;
            push(e, op, (i == nm), rnd());
         end
         if (op == 6'b100011) begin
            e = ctl(4, 0, 0); e[RW] = 1'b1; e[M2R] = 1'b1;
            push(e, op, rnd(), rnd());
         end
      end else if (op == 6'b000000) begin
         e = ctl(6, 0, 2); e[SA] = 1'b1;
         push(e, op, rnd(), rnd());
         e = ctl(7, 0, 0); e[RW] = 1'b1; e[RD] = 1'b1;
         push(e, op, rnd(), rnd());
      end else if (op == 6'b001000) begin
         e = ctl(10, 2, 0); e[SA] = 1'b1;
         push(e, op, rnd(), rnd());
         e = ctl(11, 0, 0); e[RW] = 1'b1;
         push(e, op, rnd(), rnd());
      end else if (op == 6'b000100) begin
         e = ctl(8, 0, 1); e[SA] = 1'b1; e[BR] = z;
         push(e, op, rnd(), z);
      end else if (op == 6'b000010) begin
         e = ctl(9, 0, 0); e[JMP] = 1'b1;
         push(e, op, rnd(), rnd());
      end
   endtask

   task automatic check(input string tag, input logic [19:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Steps the DUT through every queued cycle and empties the queue.
   task automatic run(input string tag);
      step_t s;
      int n;
      n = 0;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(posedge clk);
         #1;
         opcode = s.op; mem_ready = s.mr; zero = s.z;
         @(negedge clk);
         check($sformatf("%s_c%0d", tag, n), s.e);
         total++;
         assert ($countones({pc_write, branch, jump}) <= 1) else begin
            bad++;
            $error("FAIL %s_c%0d_onehot obs=%b exp=at_most_one", tag, n, {pc_write, branch, jump});
         end
         $display("%s cycle %0d state=%0d op=%b mr=%b z=%b", tag, n, state, s.op, s.mr, s.z);
         n++;
      end
   endtask

   // Called at a negedge; the following rising edge sees a stalled FETCH.
   task automatic release_reset();
      logic [19:0] e;
      mem_ready = 1'b0;
      reset_n = 1'b1;
      #1;
      e = ctl(0, 1, 0); e[MR] = 1'b1;
      check("release_fetch", e);
   endtask

   initial begin
      logic [5:0] ops [6];
      logic [5:0] op;
      ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
      ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
      reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b100011;

      // Reset: everything forced low even with mem_ready high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset_c%0d", i), 20'h0);
      end
      release_reset();

      // R-type then addi, zero wait states
      gen(6'b000000, 1'b0, 0, 0, 0); gen(6'b001000, 1'b0, 0, 0, 0); run("r_addi");
      // lw with two fetch stalls and three read stalls
      gen(6'b100011, 1'b0, 2, 3, 0); run("lw_stall");
      // beq taken, beq not taken, jump
      gen(6'b000100, 1'b1, 0, 0, 0); gen(6'b000100, 1'b0, 0, 0, 0);
      gen(6'b000010, 1'b0, 0, 0, 0); run("beq_j");
      // Illegal opcode
      gen(6'b111111, 1'b0, 0, 0, 0); run("illegal");
      // sw zero wait
      gen(6'b101011, 1'b0, 0, 0, 0); run("sw");

      // Random instruction mix with random stalls
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom_range(0, 63));
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         gen(op, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
         run($sformatf("rand%0d", k));
      end

      // sw interrupted by reset during a stalled MEMWR
      gen(6'b101011, 1'b0, 1, 3, 1); run("sw_abort");
      #2 reset_n = 1'b0;
      #1 check("abort_immediate", 20'h0);
      @(negedge clk);
      check("abort_held", 20'h0);
      release_reset();
      gen(6'b000000, 1'b0, 1, 0, 0); run("after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
